cacheline_adapter: RTL and testbench
====================================

CACHELINE_ADAPTER -- requirements
Module: cacheline_adapter

Interface
REQ-001 SHALL have parameter s_line, default 256, cacheline width in bits.
REQ-002 SHALL have parameter s_burst, default 64, memory beat width in bits; beats per line = s_line/s_burst (4 at defaults).
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port line_i  input  s_line  write line from L2 cache (driven by the cache's pmem_wdata).
REQ-006 SHALL have port line_o  output  s_line  read line to L2 cache (drives the cache's pmem_rdata).
REQ-007 SHALL have port address_i  input  32  line address from L2 cache.
REQ-008 SHALL have port read_i  input  1  line read request from L2 cache.
REQ-009 SHALL have port write_i  input  1  line write request from L2 cache.
REQ-010 SHALL have port resp_o  output  1  line transfer complete, to L2 cache pmem_resp.
REQ-011 SHALL have port burst_i  input  s_burst  read beat from memory.
REQ-012 SHALL have port burst_o  output  s_burst  write beat to memory.
REQ-013 SHALL have port address_o  output  32  burst base address to memory.
REQ-014 SHALL have port read_o  output  1  burst read request to memory.
REQ-015 SHALL have port write_o  output  1  burst write request to memory.
REQ-016 SHALL have port resp_i  input  1  memory beat accepted/valid, one beat per high cycle.

Function
REQ-017 SHALL implement FSM states IDLE, READ, WRITE, DONE, with a beat counter of width log2(beats).
REQ-018 In IDLE with read_i=1: latch {address_i[31:5],5'b0} into address_o, clear counter, go to READ next cycle.
REQ-019 In IDLE with write_i=1 and read_i=0: latch the aligned address and line_i, clear counter, go to WRITE next cycle.
REQ-020 In IDLE with read_i=1 and write_i=1 simultaneously: read wins and write_i is ignored.
REQ-021 read_o SHALL be 1 exactly while in READ; write_o SHALL be 1 exactly while in WRITE; address_o SHALL hold stable throughout READ, WRITE and DONE.
REQ-022 In READ, each cycle with resp_i=1: store burst_i into line_o[count*s_burst +: s_burst] and increment the counter. Beat 0 maps to bits 63:0.
REQ-023 In READ, when resp_i=1 on the final beat (count=beats-1), the next state SHALL be DONE.
REQ-024 In WRITE, burst_o SHALL equal latched_line[count*s_burst +: s_burst]; the counter SHALL advance on each resp_i=1, going to DONE after the final beat.
REQ-025 In READ or WRITE with resp_i=0: hold state, counter and outputs (unbounded memory wait).
REQ-026 DONE SHALL last exactly one cycle with resp_o=1, then return to IDLE; resp_o SHALL be 0 in all other states.
REQ-027 line_o SHALL be complete and valid during the DONE cycle of a read, and SHALL hold until the next read overwrites it.
REQ-028 resp_i SHALL be ignored in IDLE and DONE; read_i/write_i SHALL be ignored outside IDLE. The requester drops its request in the cycle after resp_o, so no duplicate transfer starts.
REQ-029 Latency: request sampled in IDLE at cycle N gives read_o/write_o at N+1; with resp_i held high from N+1 through N+4, resp_o SHALL be 1 at N+5.
REQ-030 The counter SHALL wrap to 0 on the final beat, so no stale count carries into the next transfer.
REQ-031 burst_o SHALL be 0 outside WRITE.

Reset
REQ-032 rst=1 at a clock edge SHALL force IDLE, counter=0, resp_o=0, read_o=0, write_o=0, address_o=0, line_o=0, and latched line=0.
REQ-033 rst asserted mid-READ or mid-WRITE SHALL abort the burst with no resp_o. The next request after reset SHALL start from beat 0.
REQ-034 rst SHALL take priority over every other input in the same cycle.

Verification
REQ-035 Read: address_i=0x0000_1234, read_i=1; memory returns beats 0x11..11, 0x22..22, 0x33..33, 0x44..44 on consecutive resp_i -> address_o=0x0000_1220, resp_o at N+5, line_o={0x44..44,0x33..33,0x22..22,0x11..11}.
REQ-036 Write: line_i=256'h0123..CDEF pattern, address_i=0x8000_00FF, write_i=1 -> address_o=0x8000_00E0, burst_o emits line bits 63:0, 127:64, 191:128, 255:192 in order, resp_o one cycle after the 4th resp_i.
REQ-037 Stalled memory: resp_i toggles 1,0,0,1,1,0,1 -> exactly 4 beats captured, read_o held high throughout, a single resp_o pulse.
REQ-038 Simultaneous read_i=write_i=1 in IDLE -> read_o=1, write_o=0, READ sequence runs.
REQ-039 rst pulsed after 2 read beats -> read_o=0 and resp_o=0 next cycle; a following read completes with 4 fresh beats and correct line_o.
REQ-040 Back-to-back: write then read with the request held 1 cycle past resp_o -> no extra transfer; the second transfer starts only after IDLE.

Source files
------------

// File: rtl/cacheline_adapter.sv
// Converts L2 cacheline read/write requests into s_line/s_burst memory beats (beat 0 = low bits).
// Latency: request at N -> read_o/write_o at N+1 -> resp_o one cycle after the final beat; waits indefinitely while resp_i is low.
module cacheline_adapter #(
  parameter int s_line  = 256,
  parameter int s_burst = 64
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [s_line-1:0]  line_i,
  output logic [s_line-1:0]  line_o,
  input  logic [31:0]        address_i,
  input  logic               read_i,
  input  logic               write_i,
  output logic               resp_o,
  input  logic [s_burst-1:0] burst_i,
  output logic [s_burst-1:0] burst_o,
  output logic [31:0]        address_o,
  output logic               read_o,
  output logic               write_o,
  input  logic               resp_i
);

  localparam int beats = s_line / s_burst;
  localparam int cnt_w = (beats > 1) ? $clog2(beats) : 1;
  localparam int off_w = $clog2(s_line / 8);

  typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

  state_t            state_q, state_d;
  logic [cnt_w-1:0]  cnt_q;
  logic [s_line-1:0] wline_q;
  logic              last_beat;
  logic              unused_addr_bits;

  // Byte offset within the line is dropped; memory always sees line-aligned addresses.
  assign unused_addr_bits = ^address_i[off_w-1:0];
  assign last_beat        = resp_i && (cnt_q == cnt_w'(beats - 1));

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (read_i) state_d = READ;
               else if (write_i) state_d = WRITE;
      READ:    if (last_beat) state_d = DONE;
      WRITE:   if (last_beat) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q     <= '0;
      address_o <= '0;
      line_o    <= '0;
      wline_q   <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (read_i || write_i) begin
            address_o <= {address_i[31:off_w], {off_w{1'b0}}};
            cnt_q     <= '0;
            if (!read_i) wline_q <= line_i;
          end
        end
        READ: begin
          if (resp_i) begin
            line_o[int'(cnt_q)*s_burst +: s_burst] <= burst_i;
            cnt_q <= last_beat ? '0 : cnt_q + cnt_w'(1);
          end
        end
        WRITE: begin
          if (resp_i) cnt_q <= last_beat ? '0 : cnt_q + cnt_w'(1);
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    burst_o = '0;
    if (state_q == WRITE) burst_o = wline_q[int'(cnt_q)*s_burst +: s_burst];
  end

  assign read_o  = (state_q == READ);
  assign write_o = (state_q == WRITE);
  assign resp_o  = (state_q == DONE);

endmodule

// File: tb/tb_cacheline_adapter.sv
// Randomized bench for cacheline_adapter: line-level reference model checked every cycle.
module tb_cacheline_adapter;

  logic         clk = 1'b0;
  logic         rst;
  logic [255:0] line_i, line_o;
  logic [31:0]  address_i, address_o;
  logic         read_i, write_i, resp_o;
  logic [63:0]  burst_i, burst_o;
  logic         read_o, write_o, resp_i;

  int vectors = 0;
  int miscompares = 0;
  logic [255:0] last_line = '0;

  cacheline_adapter dut (
    .clk(clk), .rst(rst), .line_i(line_i), .line_o(line_o),
    .address_i(address_i), .read_i(read_i), .write_i(write_i), .resp_o(resp_o),
    .burst_i(burst_i), .burst_o(burst_o), .address_o(address_o),
    .read_o(read_o), .write_o(write_o), .resp_i(resp_i)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] rnd64();
    return {$urandom, $urandom};
  endfunction

  function automatic logic [255:0] rnd256();
    return {rnd64(), rnd64(), rnd64(), rnd64()};
  endfunction

  // One line transfer. pat_len>0 replays a fixed resp_i pattern, otherwise resp_i
  // stalls with probability stall_pct. abort_at>=0 pulses rst once that many beats are done.
  task automatic xfer(input bit rd, input bit wr, input logic [31:0] addr,
                      input logic [255:0] wline, input logic [255:0] rline,
                      input int stall_pct, input logic [15:0] pat, input int pat_len,
                      input int abort_at);
    logic [63:0] rb [4];
    logic [63:0] wb [4];
    logic [31:0] exp_addr;
    bit          r;
    int          beat;
    int          cyc;
    exp_addr = addr & 32'hFFFF_FFE0;
    for (int i = 0; i < 4; i++) begin
      rb[i] = rline[64*i +: 64];
      wb[i] = wline[64*i +: 64];
    end
    read_i = rd; write_i = wr; address_i = addr; line_i = wline; resp_i = $urandom_range(1);
    @(posedge clk); #1;
    // Scramble request-side inputs: the adapter must work from its latched copies.
    line_i = rnd256(); address_i = $urandom;
    beat = 0; cyc = 0;
    while (beat < 4 && cyc < 200) begin
      chk("read_o", read_o, rd);
      chk("write_o", write_o, !rd);
      chk("resp_o_busy", resp_o, 0);
      chk("address_o", address_o, exp_addr);
      chk("burst_o", burst_o, rd ? 64'h0 : wb[beat]);
      if (!rd) chk("line_o_hold", line_o, last_line);
      if (abort_at == beat) begin
        rst = 1'b1; resp_i = 1'b1; burst_i = rnd64();
        @(posedge clk); #1;
        rst = 1'b0; read_i = 1'b0; write_i = 1'b0; resp_i = 1'b0;
        last_line = '0;
        chk("rst_read_o", read_o, 0);
        chk("rst_write_o", write_o, 0);
        chk("rst_resp_o", resp_o, 0);
        chk("rst_address_o", address_o, 0);
        chk("rst_line_o", line_o, 0);
        chk("rst_burst_o", burst_o, 0);
        @(posedge clk); #1;
        chk("rst_idle_resp_o", resp_o, 0);
        return;
      end
      if (pat_len > 0) r = (cyc < pat_len) ? pat[cyc] : 1'b1;
      else             r = ($urandom_range(99) >= stall_pct);
      resp_i  = r;
      burst_i = (r && rd) ? rb[beat] : rnd64();
      @(posedge clk); #1;
      if (r) beat++;
      cyc++;
    end
    chk("beats_done", beat, 4);
    if (rd) last_line = {rb[3], rb[2], rb[1], rb[0]};
    chk("done_resp_o", resp_o, 1);
    chk("done_read_o", read_o, 0);
    chk("done_write_o", write_o, 0);
    chk("done_burst_o", burst_o, 0);
    chk("done_address_o", address_o, exp_addr);
    chk("done_line_o", line_o, last_line);
    // Request is still held during DONE; resp_i noise must be ignored too.
    resp_i = $urandom_range(1); burst_i = rnd64();
    @(posedge clk); #1;
    read_i = 1'b0; write_i = 1'b0;
    for (int k = 0; k < 2; k++) begin
      chk("idle_resp_o", resp_o, 0);
      chk("idle_read_o", read_o, 0);
      chk("idle_write_o", write_o, 0);
      chk("idle_burst_o", burst_o, 0);
      chk("idle_line_o", line_o, last_line);
      resp_i = $urandom_range(1); burst_i = rnd64();
      @(posedge clk); #1;
    end
  endtask

  initial begin
    logic [255:0] rl;
    logic [255:0] wl;
    bit           rd;
    bit           wr;
    rst = 1'b1; read_i = 1'b0; write_i = 1'b0; resp_i = 1'b1;
    address_i = 32'hFFFF_FFFF; line_i = '1; burst_i = '1;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_resp_o", resp_o, 0);
    chk("reset_read_o", read_o, 0);
    chk("reset_write_o", write_o, 0);
    chk("reset_address_o", address_o, 0);
    chk("reset_line_o", line_o, 0);
    chk("reset_burst_o", burst_o, 0);
    rst = 1'b0; resp_i = 1'b0;
    @(posedge clk); #1;

    // Directed read, no stalls: resp_o lands exactly five cycles after the request edge.
    rl = {{16{4'h4}}, {16{4'h3}}, {16{4'h2}}, {16{4'h1}}};
    xfer(1, 0, 32'h0000_1234, '0, rl, 0, 16'h0, 0, -1);
    // Directed write.
    wl = 256'h0123456789ABCDEF_1032547698BADCFE_2301674589EFCDAB_3210765498FEDCBA;
    xfer(0, 1, 32'h8000_00FF, wl, '0, 0, 16'h0, 0, -1);
    // Stalled memory: resp_i 1,0,0,1,1,0,1.
    xfer(1, 0, 32'h0000_4000, '0, rnd256(), 0, 16'h0059, 7, -1);
    // Simultaneous read and write: read wins.
    xfer(1, 1, $urandom, rnd256(), rnd256(), 30, 16'h0, 0, -1);
    // Abort a read after 2 beats, then a fresh read.
    xfer(1, 0, $urandom, '0, rnd256(), 0, 16'h0, 0, 2);
    xfer(1, 0, $urandom, '0, rnd256(), 20, 16'h0, 0, -1);
    // Abort a write after 1 beat, then a fresh write.
    xfer(0, 1, $urandom, rnd256(), '0, 0, 16'h0, 0, 1);
    xfer(0, 1, $urandom, rnd256(), '0, 20, 16'h0, 0, -1);
    // Back-to-back write then read.
    xfer(0, 1, $urandom, rnd256(), '0, 0, 16'h0, 0, -1);
    xfer(1, 0, $urandom, '0, rnd256(), 0, 16'h0, 0, -1);

    for (int t = 0; t < 40; t++) begin
      rd = $urandom_range(1);
      wr = rd ? 1'($urandom_range(1)) : 1'b1;
      xfer(rd, wr, $urandom, rnd256(), rnd256(), $urandom_range(60), 16'h0, 0, -1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
